// File: rtl/merge_pass_sched.sv
// Bottom-up merge-sort pass scheduler for a two-bank ping-pong sample memory.
// Each pass issues merge-segment descriptors (run width 1, 2, 4, ...) to the
// merge engine, waits for every segment of the pass to complete, then flips
// the source bank. No sample data passes through this block.
module merge_pass_sched #(
  parameter int MAX_NUM_SAMPLES = 2**16,
  parameter int MEM_ADDR_WIDTH  = $clog2(MAX_NUM_SAMPLES),
  parameter int CNT_W           = MEM_ADDR_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  output logic             busy,
  output logic             done,
  output logic             result_bank,
  output logic [4:0]       pass_count,
  output logic             cfg_err,
  output logic             seg_valid,
  input  logic             seg_ready,
  output logic [CNT_W-1:0] seg_lo,
  output logic [CNT_W-1:0] seg_mid,
  output logic [CNT_W-1:0] seg_hi,
  output logic             seg_src_bank,
  input  logic             seg_done
);

  // One spare bit so lo + 2w never wraps before it is clipped to n.
  localparam int SW = CNT_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_NEXT, S_FIN} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] n_q, lo_q, w_q, outstanding_q;
  logic             src_bank_q;
  logic             busy_q, done_q, result_bank_q, cfg_err_q;
  logic [4:0]       pass_count_q;
  logic             seg_valid_q, seg_src_bank_q;
  logic [CNT_W-1:0] seg_lo_q, seg_mid_q, seg_hi_q;

  logic             hs, done_ok, start_ok;
  logic [SW-1:0]    lo_nxt;
  logic [CNT_W-1:0] w_dbl;

  // Clip an extended-width bound to the sample count.
  function automatic logic [CNT_W-1:0] clip(input logic [SW-1:0] v,
                                            input logic [CNT_W-1:0] n);
    return (v > SW'(n)) ? n : v[CNT_W-1:0];
  endfunction

  assign hs       = seg_valid_q & seg_ready;
  // A completion with nothing outstanding is spurious and dropped.
  assign done_ok  = seg_done & (outstanding_q != '0);
  assign start_ok = (num_samples != '0) && (num_samples <= CNT_W'(MAX_NUM_SAMPLES));
  assign lo_nxt   = SW'(lo_q) + (SW'(w_q) << 1);
  assign w_dbl    = w_q << 1;

  // Pass sequencing, descriptor generation and outstanding-segment tracking.
  // NOTE: every state register here uses <= so all updates see pre-edge values;
  // a blocking = would let later statements observe half-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      lo_q           <= '0;
      w_q            <= CNT_W'(1);
      outstanding_q  <= '0;
      src_bank_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_bank_q  <= 1'b0;
      cfg_err_q      <= 1'b0;
      pass_count_q   <= '0;
      seg_valid_q    <= 1'b0;
      seg_src_bank_q <= 1'b0;
      seg_lo_q       <= '0;
      seg_mid_q      <= '0;
      seg_hi_q       <= '0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;

      // A handshake and a completion in the same cycle cancel out.
      if (hs && !done_ok)      outstanding_q <= outstanding_q + CNT_W'(1);
      else if (done_ok && !hs) outstanding_q <= outstanding_q - CNT_W'(1);

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              n_q          <= num_samples;
              pass_count_q <= '0;
              src_bank_q   <= 1'b0;
              w_q          <= CNT_W'(1);
              lo_q         <= '0;
              busy_q       <= 1'b1;
              if (num_samples == CNT_W'(1)) begin
                state_q <= S_FIN;
              end else begin
                state_q        <= S_ISSUE;
                seg_valid_q    <= 1'b1;
                seg_lo_q       <= '0;
                seg_mid_q      <= clip(SW'(1), num_samples);
                seg_hi_q       <= clip(SW'(2), num_samples);
                seg_src_bank_q <= 1'b0;
              end
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (hs) begin
            lo_q <= lo_nxt[CNT_W-1:0];
            if (lo_nxt >= SW'(n_q)) begin
              seg_valid_q <= 1'b0;
              state_q     <= S_DRAIN;
            end else begin
              seg_lo_q  <= lo_nxt[CNT_W-1:0];
              seg_mid_q <= clip(lo_nxt + SW'(w_q), n_q);
              seg_hi_q  <= clip(lo_nxt + (SW'(w_q) << 1), n_q);
            end
          end
        end

        S_DRAIN: begin
          if (outstanding_q == '0) state_q <= S_NEXT;
        end

        S_NEXT: begin
          pass_count_q <= pass_count_q + 5'd1;
          src_bank_q   <= ~src_bank_q;
          w_q          <= w_dbl;
          lo_q         <= '0;
          if (w_dbl >= n_q) begin
            state_q <= S_FIN;
          end else begin
            state_q        <= S_ISSUE;
            seg_valid_q    <= 1'b1;
            seg_lo_q       <= '0;
            seg_mid_q      <= clip(SW'(w_dbl), n_q);
            seg_hi_q       <= clip(SW'(w_dbl) << 1, n_q);
            seg_src_bank_q <= ~src_bank_q;
          end
        end

        S_FIN: begin
          done_q        <= 1'b1;
          result_bank_q <= src_bank_q;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_bank  = result_bank_q;
  assign pass_count   = pass_count_q;
  assign cfg_err      = cfg_err_q;
  assign seg_valid    = seg_valid_q;
  assign seg_lo       = seg_lo_q;
  assign seg_mid      = seg_mid_q;
  assign seg_hi       = seg_hi_q;
  assign seg_src_bank = seg_src_bank_q;

endmodule

// File: tb/tb_merge_pass_sched.sv
// Self-checking bench for merge_pass_sched: table of sort runs with
// expected segment lists, plus hand-written config-error and abort sequences.
module tb_merge_pass_sched;

  localparam int CNT_W = 17;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             busy, done, result_bank, cfg_err, seg_valid, seg_src_bank;
  logic [4:0]       pass_count;
  logic [CNT_W-1:0] seg_lo, seg_mid, seg_hi;
  logic             seg_ready = 1'b0;
  logic             seg_done = 1'b0;

  merge_pass_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .busy         (busy),
    .done         (done),
    .result_bank  (result_bank),
    .pass_count   (pass_count),
    .cfg_err      (cfg_err),
    .seg_valid    (seg_valid),
    .seg_ready    (seg_ready),
    .seg_lo       (seg_lo),
    .seg_mid      (seg_mid),
    .seg_hi       (seg_hi),
    .seg_src_bank (seg_src_bank),
    .seg_done     (seg_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    bit stall;      // random seg_ready stalls and 0-20 cycle completion latency
    bit inject;     // pulse an extra start while busy
    int exp_passes;
    bit exp_bank;
  } vec_t;

  vec_t        vecs[7];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [51:0] exp_q[$];
  logic [51:0] cur_desc;

  assign cur_desc = {seg_src_bank, seg_lo, seg_mid, seg_hi};

  task automatic check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [51:0] pack(input int src, input int lo, input int mid, input int hi);
    return {src[0], lo[16:0], mid[16:0], hi[16:0]};
  endfunction

  // Expected descriptor stream: hand-written for n=8 and n=5, loop model otherwise.
  task automatic build_exp(input int n);
    int p;
    exp_q.delete();
    if (n == 8) begin
      exp_q.push_back(pack(0, 0, 1, 2)); exp_q.push_back(pack(0, 2, 3, 4));
      exp_q.push_back(pack(0, 4, 5, 6)); exp_q.push_back(pack(0, 6, 7, 8));
      exp_q.push_back(pack(1, 0, 2, 4)); exp_q.push_back(pack(1, 4, 6, 8));
      exp_q.push_back(pack(0, 0, 4, 8));
    end else if (n == 5) begin
      exp_q.push_back(pack(0, 0, 1, 2)); exp_q.push_back(pack(0, 2, 3, 4));
      exp_q.push_back(pack(0, 4, 5, 5));
      exp_q.push_back(pack(1, 0, 2, 4)); exp_q.push_back(pack(1, 4, 5, 5));
      exp_q.push_back(pack(0, 0, 4, 5));
    end else begin
      p = 0;
      for (int w = 1; w < n; w = w * 2) begin
        for (int lo = 0; lo < n; lo = lo + 2 * w) begin
          exp_q.push_back(pack(p, lo,
                               (lo + w < n) ? lo + w : n,
                               (lo + 2 * w < n) ? lo + 2 * w : n));
        end
        p++;
      end
    end
  endtask

  // Run one sort, acting as the merge engine; abort_at>0 asserts reset at that cycle.
  task automatic run_sort(input vec_t v, input int abort_at);
    logic [51:0] obs[$];
    int          due_q[$];
    int          cyc, last_due, budget, d;
    bit          prev_stall, first, got_done;
    logic [51:0] prev_desc;
    logic        last_src;
    cyc = 0; last_due = 0; prev_stall = 0; first = 1; got_done = 0;
    prev_desc = '0; last_src = 1'b0;
    budget = 3 * v.n + 3000;
    build_exp(v.n);

    @(negedge clk);
    num_samples = CNT_W'(v.n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", busy, 1);

    forever begin
      if (abort_at != 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("outputs_in_reset",
              {busy, done, result_bank, pass_count, cfg_err, seg_valid,
               seg_lo, seg_mid, seg_hi, seg_src_bank}, 0);
        seg_ready = 1'b0;
        seg_done  = 1'b0;
        return;
      end
      if (done) begin
        got_done = 1;
        break;
      end
      if (cyc > budget) break;

      if (v.inject) begin
        if (cyc == 10) begin
          start = 1'b1;
          num_samples = CNT_W'(5);
        end else if (cyc == 11) begin
          start = 1'b0;
        end
      end

      // Completions, delivered in order at their due cycle.
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        seg_done = 1'b1;
        void'(due_q.pop_front());
      end else begin
        seg_done = 1'b0;
      end

      seg_ready = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;

      if (prev_stall)
        check("stall_stable", {seg_valid, cur_desc}, {1'b1, prev_desc});

      // First descriptor of a new pass: every prior completion must be delivered.
      if (seg_valid && (first || seg_src_bank != last_src)) begin
        if (!first) check("pass_order", {due_q.size() == 0, seg_done}, 2'b10);
        last_src = seg_src_bank;
        first = 0;
      end

      if (seg_valid && seg_ready) begin
        obs.push_back(cur_desc);
        d = cyc + 1 + (v.stall ? int'($urandom_range(0, 20)) : 0);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        due_q.push_back(d);
      end

      prev_stall = seg_valid && !seg_ready;
      prev_desc  = cur_desc;
      @(negedge clk);
      cyc++;
    end

    seg_ready = 1'b0;
    seg_done  = 1'b0;
    check("done_seen", got_done, 1);
    if (got_done) begin
      check("busy_at_done", busy, 0);
      check("pass_count", pass_count, v.exp_passes);
      check("result_bank", result_bank, v.exp_bank);
      if (v.n == 1) check("n1_done_latency", cyc, 2);
      check("seg_count", obs.size(), exp_q.size());
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
        check("segment", obs[i], exp_q[i]);
      @(negedge clk);
      check("done_pulse_width", done, 0);
    end
  endtask

  task automatic cfg_case(input int n);
    @(negedge clk);
    num_samples = CNT_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_err_pulse", {cfg_err, busy, seg_valid}, 3'b100);
    @(negedge clk);
    check("cfg_err_clear", {cfg_err, busy, seg_valid}, 3'b000);
  endtask

  initial begin
    vec_t abort_v;
    vecs[0] = '{1,     1'b0, 1'b0, 0,  1'b0};
    vecs[1] = '{8,     1'b0, 1'b0, 3,  1'b1};
    vecs[2] = '{5,     1'b0, 1'b0, 3,  1'b1};
    vecs[3] = '{37,    1'b1, 1'b1, 6,  1'b0};
    vecs[4] = '{2,     1'b0, 1'b0, 1,  1'b1};
    vecs[5] = '{3,     1'b0, 1'b0, 2,  1'b0};
    vecs[6] = '{65536, 1'b0, 1'b0, 16, 1'b0};
    abort_v = '{100,   1'b0, 1'b0, 0,  1'b0};

    #12;
    check("reset_outputs",
          {busy, done, result_bank, pass_count, cfg_err, seg_valid,
           seg_lo, seg_mid, seg_hi, seg_src_bank}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    cfg_case(0);
    cfg_case(65537);

    for (int i = 0; i < 6; i++) run_sort(vecs[i], 0);

    // Reset mid-pass: no done pulse, block returns to idle.
    run_sort(abort_v, 30);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_after_abort", {done, busy, seg_valid}, 3'b000);
    end

    run_sort(vecs[6], 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
